// File: rtl/core_pkg.sv
// Shared core definitions: fetch buffer entry type and fetch-related constants.
package core_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;  // addi x0, x0, 0

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, instr} pairs between instruction memory and decode.
module fetch_fifo
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;

  // Entry storage write.
  // NOTE: the data array has no reset; validity is carried by count_q, so
  // clearing the payload would only add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = count_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential fetches to a synchronous
// instruction memory, buffers returning words, and offers them to decode
// with a valid/ready handshake. Redirects flush everything in flight.
module if_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  logic [31:0]  pc_q;
  logic         inflight;
  logic [31:0]  inflight_pc;

  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_push_data;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  logic         pop;
  logic [2:0]   occupancy;

  assign fifo_empty     = (fifo_count == 2'd0);
  assign imem_pc        = align_pc(pc_q);
  assign fifo_push_data = '{pc: inflight_pc, instr: imem_instr};

  // Offer selection, handshake, buffer control and fetch throttling.
  // NOTE: every output gets a default first so no path through the block
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    id_valid  = 1'b0;
    id_pc     = 32'd0;
    id_instr  = 32'd0;
    pop       = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    imem_en   = 1'b0;
    occupancy = 3'd0;
    if (!rst && !redirect_valid) begin
      if (!fifo_empty) begin
        id_valid = 1'b1;
        id_pc    = fifo_head.pc;
        id_instr = fifo_head.instr;
      end else if (inflight) begin
        // Fall-through: the word arriving from memory goes straight to decode.
        id_valid = 1'b1;
        id_pc    = inflight_pc;
        id_instr = imem_instr;
      end
      pop       = id_valid & id_ready;
      fifo_pop  = pop & ~fifo_empty;
      // A returning word is buffered unless decode takes it directly.
      fifo_push = inflight & ~(pop & fifo_empty);
      // Slots committed after this edge; a new fetch needs one to be free.
      occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
      imem_en   = (occupancy < 3'd2);
    end
  end

  // Fetch PC and in-flight tracking; a redirect overrides any issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
    end else if (redirect_valid) begin
      pc_q     <= align_pc(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= imem_pc;
        pc_q        <= imem_pc + 32'd4;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. The reference model tracks the fetch
// stream in program order: next address to fetch, next address to offer,
// and how many fetched words are outstanding (issued but not yet accepted).
module tb_if_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  // Second instance for address wrap-around.
  logic        rst_w = 1'b1;
  logic        imem_en_w;
  logic [31:0] imem_pc_w;
  logic [31:0] imem_instr_w = 32'd0;
  logic        redirect_valid_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'd0;
  logic        id_valid_w;
  logic        id_ready_w = 1'b1;
  logic [31:0] id_pc_w;
  logic [31:0] id_instr_w;

  int errors = 0;
  int checks = 0;

  // Model state.
  int          m_out;
  logic [31:0] m_fetch;
  logic [31:0] m_next_id;

  // Expectations for the current cycle, filled in by apply().
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_en;
  logic [31:0] exp_ipc;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk            (clk),
    .rst            (rst_w),
    .imem_en        (imem_en_w),
    .imem_pc        (imem_pc_w),
    .imem_instr     (imem_instr_w),
    .redirect_valid (redirect_valid_w),
    .redirect_pc    (redirect_pc_w),
    .id_valid       (id_valid_w),
    .id_ready       (id_ready_w),
    .id_pc          (id_pc_w),
    .id_instr       (id_instr_w)
  );

  // Program image: a short straight-line prologue, then a scrambled pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0010_0313;  // addi x6, x0, 1
      32'h4:   return 32'h0020_0393;  // addi x7, x0, 2
      32'h8:   return 32'h0073_0433;  // add  x8, x6, x7
      32'hC:   return 32'h0074_04B3;  // add  x9, x8, x7
      32'h10:  return 32'h4064_0533;  // sub  x10, x8, x6
      default: return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endcase
  endfunction

  // Synchronous instruction memories: data appears the cycle after the request.
  always @(posedge clk) if (imem_en)   imem_instr   <= rom_word(imem_pc);
  always @(posedge clk) if (imem_en_w) imem_instr_w <= rom_word(imem_pc_w);

  task automatic model_reset();
    m_out     = 0;
    m_fetch   = DEFAULT_RESET_PC;
    m_next_id = DEFAULT_RESET_PC;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    model_reset();
    @(negedge clk);
  endtask

  // Drive one cycle (also releases reset), compute expectations, advance model.
  task automatic apply(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic pop_e;
    @(negedge clk);
    rst = 1'b0; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    exp_valid = !rv && (m_out > 0);
    exp_pc    = m_next_id;
    exp_instr = rom_word(m_next_id);
    pop_e     = exp_valid && rdy;
    exp_en    = !rv && ((m_out - int'(pop_e)) < 2);
    exp_ipc   = m_fetch;
    if (rv) begin
      m_out     = 0;
      m_fetch   = {rpc[31:2], 2'b00};
      m_next_id = m_fetch;
    end else begin
      if (pop_e)  begin m_out--; m_next_id += 32'd4; end
      if (exp_en) begin m_out++; m_fetch   += 32'd4; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
    checks++; if (id_pc !== 32'd0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    checks++; if (id_instr !== 32'd0) begin errors++; $display("FAIL reset_id_instr: got %h expected 0", id_instr); end
    checks++; if (imem_pc !== 32'd0) begin errors++; $display("FAIL reset_imem_pc: got %h expected 0", imem_pc); end
    // First cycle after release issues the reset PC.
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (imem_en !== 1'b1 || imem_pc !== 32'd0) begin errors++; $display("FAIL reset_first_fetch: got en=%b pc=%h expected en=1 pc=0", imem_en, imem_pc); end
  endtask

  task automatic test_streaming();
    logic [31:0] seen[$];
    logic [31:0] want [5];
    int          valid_cycles;
    want = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    valid_cycles = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 32'd0);
      checks++; if (id_valid !== exp_valid) begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", i, id_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL stream_pc c%0d: got %h expected %h", i, id_pc, exp_pc); end
        checks++; if (id_instr !== exp_instr) begin errors++; $display("FAIL stream_instr c%0d: got %h expected %h", i, id_instr, exp_instr); end
      end
      checks++; if (imem_en !== exp_en) begin errors++; $display("FAIL stream_en c%0d: got %b expected %b", i, imem_en, exp_en); end
      if (i == 1) begin
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0010_0313) begin
          errors++; $display("FAIL stream_first: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=00100313", id_valid, id_pc, id_instr);
        end
      end
      if (id_valid === 1'b1) valid_cycles++;
      if (id_valid === 1'b1 && id_ready) seen.push_back(id_pc);
    end
    checks++; if (valid_cycles != 7) begin errors++; $display("FAIL stream_throughput: got %0d valid cycles expected 7", valid_cycles); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (seen.size() <= k) begin errors++; $display("FAIL stream_order[%0d]: got nothing expected %h", k, want[k]); end
      else if (seen[k] !== want[k]) begin errors++; $display("FAIL stream_order[%0d]: got %h expected %h", k, seen[k], want[k]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] seen[$];
    do_reset();
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 3; j++) begin
      apply(1'b0, 1'b0, 32'd0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== rom_word(32'h8)) begin
        errors++; $display("FAIL stall_hold s%0d: got v=%b pc=%h expected v=1 pc=8", j, id_valid, id_pc);
      end
      checks++; if (imem_en !== (j == 0)) begin errors++; $display("FAIL stall_en s%0d: got %b expected %b", j, imem_en, (j == 0)); end
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 32'd0);
      if (id_valid === 1'b1) seen.push_back(id_pc);
    end
    checks++;
    if (seen.size() < 3 || seen[0] !== 32'h8 || seen[1] !== 32'hC || seen[2] !== 32'h10) begin
      errors++; $display("FAIL stall_resume: got %0d entries first=%h expected 8,C,10", seen.size(), (seen.size() > 0) ? seen[0] : 32'hX);
    end
  endtask

  task automatic test_redirect();
    int eights;
    eights = 0;
    do_reset();
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 32'd0);  // PC 8 now in flight
    apply(1'b1, 1'b1, 32'h0000_0100);
    checks++; if (id_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL redir_cycle: got v=%b en=%b expected 0 0", id_valid, imem_en); end
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (id_valid !== 1'b0 || imem_en !== 1'b1 || imem_pc !== 32'h100) begin
      errors++; $display("FAIL redir_fetch: got v=%b en=%b pc=%h expected v=0 en=1 pc=100", id_valid, imem_en, imem_pc);
    end
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== rom_word(32'h100)) begin
      errors++; $display("FAIL redir_offer: got v=%b pc=%h expected v=1 pc=100", id_valid, id_pc);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 32'd0);
      if (id_valid === 1'b1 && id_pc === 32'h8) eights++;
    end
    checks++; if (eights != 0) begin errors++; $display("FAIL redir_discard: got %0d offers of pc 8 expected 0", eights); end
    // Misaligned target.
    apply(1'b1, 1'b1, 32'h0000_0102);
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (imem_en !== 1'b1 || imem_pc !== 32'h100) begin errors++; $display("FAIL redir_align: got en=%b pc=%h expected en=1 pc=100", imem_en, imem_pc); end
    // Back-to-back redirects: last wins, nothing offered between.
    apply(1'b1, 1'b1, 32'h0000_0200);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_first: got v=%b expected 0", id_valid); end
    apply(1'b1, 1'b1, 32'h0000_0300);
    checks++; if (id_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL b2b_second: got v=%b en=%b expected 0 0", id_valid, imem_en); end
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (id_valid !== 1'b0 || imem_en !== 1'b1 || imem_pc !== 32'h300) begin
      errors++; $display("FAIL b2b_fetch: got v=%b en=%b pc=%h expected v=0 en=1 pc=300", id_valid, imem_en, imem_pc);
    end
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h300) begin errors++; $display("FAIL b2b_offer: got v=%b pc=%h expected v=1 pc=300", id_valid, id_pc); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    apply(1'b1, 1'b0, 32'd0);
    apply(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 32'd0);  // buffer fills to two
    checks++; if (id_valid !== 1'b1 || imem_en !== 1'b0) begin errors++; $display("FAIL mid_full: got v=%b en=%b expected v=1 en=0", id_valid, imem_en); end
    // Asynchronous pulse between clock edges.
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (id_valid !== 1'b0 || imem_en !== 1'b0 || id_pc !== 32'd0) begin
      errors++; $display("FAIL mid_async: got v=%b en=%b pc=%h expected 0 0 0", id_valid, imem_en, id_pc);
    end
    @(negedge clk);
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (imem_en !== 1'b1 || imem_pc !== 32'd0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL mid_refetch: got en=%b pc=%h v=%b expected en=1 pc=0 v=0", imem_en, imem_pc, id_valid);
    end
    apply(1'b1, 1'b0, 32'd0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin errors++; $display("FAIL mid_offer: got v=%b pc=%h expected v=1 pc=0", id_valid, id_pc); end
  endtask

  task automatic test_random();
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom % 4) != 0;
      rv  = ($urandom % 16) == 0;
      rpc = $urandom;
      apply(rdy, rv, rpc);
      checks++; if (id_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c%0d: got %b expected %b", i, id_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL rand_pc c%0d: got %h expected %h", i, id_pc, exp_pc); end
        checks++; if (id_instr !== exp_instr) begin errors++; $display("FAIL rand_instr c%0d: got %h expected %h", i, id_instr, exp_instr); end
      end
      checks++; if (imem_en !== exp_en) begin errors++; $display("FAIL rand_en c%0d: got %b expected %b", i, imem_en, exp_en); end
      if (exp_en) begin
        checks++; if (imem_pc !== exp_ipc) begin errors++; $display("FAIL rand_ipc c%0d: got %h expected %h", i, imem_pc, exp_ipc); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    @(negedge clk);
    rst_w = 1'b0;
    #1;
    checks++; if (imem_en_w !== 1'b1 || imem_pc_w !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first_fetch: got en=%b pc=%h expected en=1 pc=fffffffc", imem_en_w, imem_pc_w);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (id_valid_w === 1'b1) seen.push_back(id_pc_w);
    end
    checks++;
    if (seen.size() < 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_order: got %0d offers first=%h expected fffffffc then 0", seen.size(), (seen.size() > 0) ? seen[0] : 32'hX);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_redirect();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, with asynchronous, active-high reset.
REQ-004 SHALL have port imem_en, output, 1 bit, the fetch request to the synchronous instruction memory.
REQ-005 SHALL have port imem_pc, output, 32 bits, the byte address of the request.
REQ-006 SHALL have port imem_instr, input, 32 bits, the memory data, valid the cycle after imem_en=1.
REQ-007 SHALL have port redirect_valid, input, 1 bit, the branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc, input, 32 bits, the redirect target.
REQ-009 SHALL have port id_valid, output, 1 bit, meaning an instruction is offered to decode.
REQ-010 SHALL have port id_ready, input, 1 bit, meaning decode accepts this cycle.
REQ-011 SHALL have port id_pc, output, 32 bits, the PC of the offered instruction.
REQ-012 SHALL have port id_instr, output, 32 bits, the offered instruction word.

Function
REQ-013 SHALL hold pc_q (next fetch address); imem_pc = pc_q combinationally, bits [1:0] always 0.
REQ-014 SHALL track one in-flight flag plus inflight_pc; when imem_en=1 at an edge: inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32 wrap).
REQ-015 SHALL contain a 2-entry FIFO of {pc, instr}; pop = id_valid & id_ready.
REQ-016 SHALL drive imem_en = !rst & !redirect_valid & (fifo_count + inflight - pop) < 2; occupancy plus in-flight never exceeds 2.
REQ-017 SHALL be fall-through: when FIFO empty and inflight=1, id_valid=1, id_pc=inflight_pc, id_instr=imem_instr (issue-to-offer latency 1 cycle).
REQ-018 SHALL, when FIFO non-empty, offer the FIFO head; a returning in-flight word is pushed to the tail unless it is popped directly in the same cycle.
REQ-019 SHALL sustain one instruction per cycle with id_ready held 1.
REQ-020 SHALL hold id_valid/id_pc/id_instr stable while id_valid=1 and id_ready=0.
REQ-021 SHALL, on redirect_valid=1: force id_valid=0 and imem_en=0 that cycle, flush the FIFO, clear inflight (discard the returning word), and load pc_q<={redirect_pc[31:2],2'b00}.
REQ-022 SHALL give redirect priority over pop, push and issue in the same cycle; first fetch of redirect_pc the following cycle.
REQ-023 SHALL treat back-to-back redirects as: the last one wins, with no instruction offered between them.

Reset
REQ-024 SHALL, while rst=1, force pc_q=RESET_PC, inflight=0, FIFO empty, id_valid=0, imem_en=0, id_pc=0, id_instr=0.
REQ-025 SHALL issue the first fetch (imem_pc=RESET_PC) in the first cycle after rst deasserts; reset mid-operation discards all in-flight and buffered instructions.

Structure
REQ-026 SHALL take the fetch_entry_t struct {pc, instr}, the DEFAULT_RESET_PC constant and the INSTR_NOP constant (32'h0000_0013) from shared package core_pkg.
REQ-027 SHALL implement the 2-entry buffer as sub-module fetch_fifo (push, pop, flush, count, head).

Verification
REQ-028 SHALL cover streaming: ROM[0..4] = addi x6; addi x7; add x8; add x9; sub x10, with id_ready=1 -> id_pc 0,4,8,C,10 on consecutive cycles starting 2 cycles after rst release; id_instr[0]=32'h00100313.
REQ-029 SHALL cover stall: deassert id_ready for 3 cycles while PC 8 is offered -> id_pc holds 8; imem_en=0 once occupancy plus in-flight = 2; resume yields C, 10 with no loss or duplicate.
REQ-030 SHALL cover redirect: redirect to 32'h0000_0100 while PC 8 is in flight -> PC 8 and buffered entries never offered; next id_pc=100 two cycles later.
REQ-031 SHALL cover misaligned redirect: redirect_pc=32'h0000_0102 -> imem_pc=32'h0000_0100.
REQ-032 SHALL cover wrap: RESET_PC=32'hFFFF_FFFC -> id_pc FFFF_FFFC then 0000_0000.
REQ-033 SHALL cover reset: async rst pulse mid-stream with FIFO full -> id_valid=0 immediately; refetch from RESET_PC after release.
